d_flip_flop: RTL and testbench



---
 rtl/dff_pkg.sv | 14 +
 rtl/dff_stage.sv | 26 ++
 rtl/d_flip_flop.sv | 76 +++++++
 tb/tb_d_flip_flop.sv | 115 +++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants for the d_flip_flop register family.
//   DFF_WIDTH       default data width
//   DFF_MAX_WIDTH   widest vector default_rst_val() can describe
//   default_rst_val default reset vector (all zeros), cast down by the user
package dff_pkg;

  localparam int unsigned DFF_WIDTH     = 4;
  localparam int unsigned DFF_MAX_WIDTH = 256;

  function automatic logic [DFF_MAX_WIDTH-1:0] default_rst_val();
    return '0;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
//   clk     rising-edge clock
//   rst     synchronous reset, loads RST_VAL (priority over enable)
//   enable  1 = capture d, 0 = hold
//   d       data in
//   q       registered data out
module dff_stage #(
  parameter int unsigned            WIDTH   = 4,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_flip_flop.sv
// WIDTH-bit D register with a redundant shadow copy and sticky mismatch flag.
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   enable    load enable (1 = capture d, 0 = hold)
//   d         data in
//   inj_err   when set on a load edge the shadow captures d with bit 0 inverted
//   q         registered data out
//   mismatch  sticky; set one edge after q and shadow are seen to differ
module d_flip_flop
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL   = WIDTH'(default_rst_val()),
  parameter bit               SHADOW_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  input  logic             inj_err,
  output logic [WIDTH-1:0] q,
  output logic             mismatch
);

  dff_stage #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (d),
    .q      (q)
  );

  generate
    if (SHADOW_EN) begin : g_shadow
      logic [WIDTH-1:0] shadow_d;
      logic [WIDTH-1:0] shadow_q;
      logic             mismatch_r;

      // Bit-0 flip written per bit so WIDTH=1 needs no zero-width replication.
      always_comb begin
        shadow_d    = d;
        shadow_d[0] = d[0] ^ inj_err;
      end

      dff_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (shadow_d),
        .q      (shadow_q)
      );

      // Compares the registered copies, so the flag trails the divergence by one edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          mismatch_r <= 1'b0;
        end else begin
          mismatch_r <= mismatch_r | (q != shadow_q);
        end
      end

      assign mismatch = mismatch_r;
    end else begin : g_no_shadow
      logic unused_inj_err;
      assign unused_inj_err = inj_err;
      assign mismatch       = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop (WIDTH=4, RST_VAL=0, SHADOW_EN=1).
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] d = '0;
  logic       inj_err = 1'b0;
  logic [3:0] q;
  logic       mismatch;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  d_flip_flop #(
    .WIDTH     (4),
    .RST_VAL   (4'h0),
    .SHADOW_EN (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .d        (d),
    .inj_err  (inj_err),
    .q        (q),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       inj;
    logic [3:0] d;
    logic [3:0] exp_q;
    logic       exp_mm;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rv;

    tbl[0]  = '{"reset",          1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{"load_A",         1'b0, 1'b1, 1'b0, 4'hA, 4'hA, 1'b0};
    tbl[2]  = '{"load_5",         1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 1'b0};
    tbl[3]  = '{"hold_1",         1'b0, 1'b0, 1'b0, 4'hF, 4'h5, 1'b0};
    tbl[4]  = '{"hold_2",         1'b0, 1'b0, 1'b0, 4'hF, 4'h5, 1'b0};
    tbl[5]  = '{"load_F",         1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b0};
    tbl[6]  = '{"rst_over_en",    1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0};
    tbl[7]  = '{"load_3",         1'b0, 1'b1, 1'b0, 4'h3, 4'h3, 1'b0};
    tbl[8]  = '{"inj_hold_ign",   1'b0, 1'b0, 1'b1, 4'h8, 4'h3, 1'b0};
    tbl[9]  = '{"inj_rst_ign",    1'b1, 1'b1, 1'b1, 4'h8, 4'h0, 1'b0};
    tbl[10] = '{"inj_load_6",     1'b0, 1'b1, 1'b1, 4'h6, 4'h6, 1'b0};
    tbl[11] = '{"mm_set_load_9",  1'b0, 1'b1, 1'b0, 4'h9, 4'h9, 1'b1};
    tbl[12] = '{"mm_sticky_C",    1'b0, 1'b1, 1'b0, 4'hC, 4'hC, 1'b1};
    tbl[13] = '{"mm_rst_clear",   1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0};

    #1;
    for (int i = 0; i < 14; i++) begin
      rst     = tbl[i].rst;
      enable  = tbl[i].en;
      inj_err = tbl[i].inj;
      d       = tbl[i].d;
      step();
      chk({tbl[i].name, "_q"},  q,                tbl[i].exp_q);
      chk({tbl[i].name, "_mm"}, {3'b0, mismatch}, {3'b0, tbl[i].exp_mm});
      // Shadow captured d with bit 0 flipped on the injection edge.
      if (i == 10) chk("inj_shadow", dut.g_shadow.shadow_q, 4'h7);
    end

    // No combinational path: changing d/enable between edges leaves q alone.
    rst = 1'b0; inj_err = 1'b0; enable = 1'b1; d = 4'h2;
    step();
    chk("mid_load_2", q, 4'h2);
    d = 4'hD; enable = 1'b0;
    #3;
    chk("mid_cycle_stable", q, 4'h2);
    enable = 1'b1;
    #1;
    chk("mid_cycle_stable_en", q, 4'h2);
    step();
    chk("mid_cycle_captured", q, 4'hD);

    // Back-to-back random loads, mismatch stays clear.
    for (int i = 0; i < 5; i++) begin
      rv = 4'($urandom_range(0, 15));
      d  = rv;
      enable = 1'b1;
      step();
      chk("rand_q", q, rv);
      chk("rand_mm", {3'b0, mismatch}, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
